// File: rtl/retire_trace_unit.sv
// Retire trace producer: captures one record per retired instruction into a small FIFO
// and streams each record as four 32-bit beats on a valid/ready interface.
module retire_trace_unit #(
    parameter int DEPTH  = 4,
    parameter int ALMOST = 1,
    parameter int DROP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ret_valid_i,
    input  logic [31:0]       ret_pc_i,
    input  logic [31:0]       ret_instr_i,
    input  logic              rf_we_i,
    input  logic [4:0]        rf_addr_i,
    input  logic [31:0]       rf_data_i,
    input  logic              dm_we_i,
    input  logic [6:0]        dm_addr_i,
    input  logic [31:0]       dm_data_i,
    output logic              tr_valid_o,
    input  logic              tr_ready_i,
    output logic [31:0]       tr_data_o,
    output logic              tr_last_o,
    output logic              stall_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o
);
    // state | meaning
    // IDLE  | FIFO empty, no beat offered
    // B0    | offering pc of head record
    // B1    | offering instruction word
    // B2    | offering {seq, dm_we, dm_addr, rf_we, rf_addr}
    // B3    | offering write data, last beat; handshake pops the head

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] seq;
        logic        dm_we;
        logic [6:0]  dm_addr;
        logic        rf_we;
        logic [4:0]  rf_addr;
        logic [31:0] payload;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          new_rec;
    rec_t          head;
    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [15:0]   seq;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic [31:0]   next_pc;
    logic [31:0]   head_beat2;

    always_comb begin
        full       = (count == (AW+1)'(DEPTH));
        push       = ret_valid_i & ~full;
        drop       = ret_valid_i & full;
        pop        = (state == B3) & tr_ready_i;
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);

        new_rec.pc      = ret_pc_i;
        new_rec.instr   = ret_instr_i;
        new_rec.seq     = seq;
        new_rec.dm_we   = dm_we_i;
        new_rec.dm_addr = dm_addr_i;
        new_rec.rf_we   = rf_we_i;
        new_rec.rf_addr = rf_addr_i;
        new_rec.payload = rf_we_i ? rf_data_i : (dm_we_i ? dm_data_i : 32'd0);

        head       = mem[rd_ptr];
        head_beat2 = {head.seq, 2'b00, head.dm_we, head.dm_addr, head.rf_we, head.rf_addr};
        // With a single entry left, the next head is the record being pushed this edge.
        next_pc    = (count == (AW+1)'(1)) ? ret_pc_i : mem[rd_ptr + AW'(1)].pc;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= new_rec;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            stall_o    <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            tr_valid_o <= 1'b0;
            tr_last_o  <= 1'b0;
            tr_data_o  <= '0;
        end else begin
            if (ret_valid_i) seq <= seq + 16'd1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            stall_o <= (count_next >= (AW+1)'(DEPTH - ALMOST));
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end

            case (state)
                IDLE: if (count != '0) begin
                    state      <= B0;
                    tr_valid_o <= 1'b1;
                    tr_last_o  <= 1'b0;
                    tr_data_o  <= head.pc;
                end
                B0: if (tr_ready_i) begin
                    state     <= B1;
                    tr_data_o <= head.instr;
                end
                B1: if (tr_ready_i) begin
                    state     <= B2;
                    tr_data_o <= head_beat2;
                end
                B2: if (tr_ready_i) begin
                    state     <= B3;
                    tr_data_o <= head.payload;
                    tr_last_o <= 1'b1;
                end
                B3: if (tr_ready_i) begin
                    tr_last_o <= 1'b0;
                    if (count_next != '0) begin
                        state     <= B0;
                        tr_data_o <= next_pc;
                    end else begin
                        state      <= IDLE;
                        tr_valid_o <= 1'b0;
                        tr_data_o  <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tr_valid_o <= 1'b0;
                    tr_last_o  <= 1'b0;
                    tr_data_o  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit: table of single-record vectors plus
// hand-written sequences for overflow, back-pressure, mid-record reset and seq wrap.
module tb_retire_trace_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ret_valid_i;
    logic [31:0] ret_pc_i;
    logic [31:0] ret_instr_i;
    logic        rf_we_i;
    logic [4:0]  rf_addr_i;
    logic [31:0] rf_data_i;
    logic        dm_we_i;
    logic [6:0]  dm_addr_i;
    logic [31:0] dm_data_i;
    logic        tr_valid_o;
    logic        tr_ready_i;
    logic [31:0] tr_data_o;
    logic        tr_last_o;
    logic        stall_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;

    retire_trace_unit #(.DEPTH(4), .ALMOST(1), .DROP_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i),
        .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
        .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i),
        .tr_valid_o(tr_valid_o), .tr_ready_i(tr_ready_i), .tr_data_o(tr_data_o),
        .tr_last_o(tr_last_o), .stall_o(stall_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rf_we;
        logic [4:0]  rf_addr;
        logic [31:0] rf_data;
        logic        dm_we;
        logic [6:0]  dm_addr;
        logic [31:0] dm_data;
        logic [15:0] exp_lo;
        logic [31:0] exp_b3;
    } vec_t;

    vec_t        vecs [6];
    int          n_err = 0;
    int          n_checks = 0;
    logic [31:0] rx_data [$];
    logic        rx_last [$];
    bit          stab_en = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: note stability and accepted beats as seen just before the edge.
    task automatic cycle();
        if (stab_en && prev_hold) begin
            chk("stable_data", tr_data_o, prev_data);
            chk("stable_last", {31'd0, tr_last_o}, {31'd0, prev_last});
        end
        prev_hold = tr_valid_o && !tr_ready_i;
        prev_data = tr_data_o;
        prev_last = tr_last_o;
        if (tr_valid_o && tr_ready_i) begin
            rx_data.push_back(tr_data_o);
            rx_last.push_back(tr_last_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_in();
        ret_valid_i = 0; ret_pc_i = 0; ret_instr_i = 0;
        rf_we_i = 0; rf_addr_i = 0; rf_data_i = 0;
        dm_we_i = 0; dm_addr_i = 0; dm_data_i = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        ret_valid_i = 1; ret_pc_i = v.pc; ret_instr_i = v.instr;
        rf_we_i = v.rf_we; rf_addr_i = v.rf_addr; rf_data_i = v.rf_data;
        dm_we_i = v.dm_we; dm_addr_i = v.dm_addr; dm_data_i = v.dm_data;
    endtask

    task automatic do_reset();
        rst_i = 1;
        clear_in();
        cycle();
        cycle();
        rst_i = 0;
        cycle();
        rx_data.delete();
        rx_last.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, input bit toggle, output int used);
        used = 0;
        while (rx_data.size() < n && used < budget) begin
            if (toggle) tr_ready_i = ~tr_ready_i;
            cycle();
            used++;
        end
        chk("beat_timeout", rx_data.size(), n);
    endtask

    task automatic check_rec(input string tag, input int base, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] b2, input logic [31:0] b3);
        if (rx_data.size() >= base + 4) begin
            chk({tag, "_beat0"}, rx_data[base], pc);
            chk({tag, "_beat1"}, rx_data[base+1], instr);
            chk({tag, "_beat2"}, rx_data[base+2], b2);
            chk({tag, "_beat3"}, rx_data[base+3], b3);
            chk({tag, "_last"}, {28'd0, rx_last[base], rx_last[base+1], rx_last[base+2], rx_last[base+3]},
                32'h1);
        end
    endtask

    initial begin
        int used;
        vec_t v;

        // beat2 low half: [13]=dm_we, [12:6]=dm_addr, [5]=rf_we, [4:0]=rf_addr
        vecs[0] = '{32'h10, 32'h20080005, 1, 5'd8,  32'h5,        0, 7'h00, 32'h0,        16'h0028, 32'h5};
        vecs[1] = '{32'h14, 32'hAC0A000C, 0, 5'd0,  32'h0,        1, 7'h0C, 32'hDEADBEEF, 16'h2300, 32'hDEADBEEF};
        vecs[2] = '{32'h18, 32'h0128F820, 1, 5'd31, 32'h12345678, 1, 7'h7F, 32'hCAFEF00D, 16'h3FFF, 32'h12345678};
        vecs[3] = '{32'h1C, 32'h2000FFFF, 1, 5'd0,  32'hFFFFFFFF, 0, 7'h00, 32'h0,        16'h0020, 32'hFFFFFFFF};
        vecs[4] = '{32'h20, 32'h10000003, 0, 5'd3,  32'h111,      0, 7'h05, 32'h222,      16'h0143, 32'h0};
        vecs[5] = '{32'h7C, 32'hAC050040, 0, 5'd0,  32'h0,        1, 7'h40, 32'hA5,       16'h3000, 32'hA5};

        tr_ready_i = 1;
        do_reset();
        chk("rst_valid", {31'd0, tr_valid_o}, 0);
        chk("rst_last", {31'd0, tr_last_o}, 0);
        chk("rst_data", tr_data_o, 0);
        chk("rst_stall", {31'd0, stall_o}, 0);
        chk("rst_ovf", {31'd0, overflow_o}, 0);
        chk("rst_drop", {24'd0, drop_cnt_o}, 0);

        // Single records, ready held high; seq follows the vector index.
        for (int i = 0; i < 6; i++) begin
            rx_data.delete();
            rx_last.delete();
            apply_vec(vecs[i]);
            cycle();
            clear_in();
            chk("lat_not_yet", {31'd0, tr_valid_o}, 0);
            cycle();
            chk("lat_valid", {31'd0, tr_valid_o}, 1);
            chk("lat_beat0", tr_data_o, vecs[i].pc);
            wait_beats(4, 20, 0, used);
            check_rec("vec", 0, vecs[i].pc, vecs[i].instr, {16'(i), vecs[i].exp_lo}, vecs[i].exp_b3);
            chk("vec_idle", {31'd0, tr_valid_o}, 0);
        end

        // Overflow with ready low, then a full-FIFO retire that coincides with a pop.
        tr_ready_i = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            v = '{32'h100 + 32'(4*k), 32'h8C000000 | 32'(k), 1, 5'(k+1), 32'h1000 + 32'(k),
                  0, 7'h0, 32'h0, 16'h0, 32'h0};
            apply_vec(v);
            cycle();
            chk("ovf_stall", {31'd0, stall_o}, (k >= 2) ? 1 : 0);
            chk("ovf_drop", {24'd0, drop_cnt_o}, (k == 4) ? 1 : 0);
        end
        clear_in();
        chk("ovf_flag", {31'd0, overflow_o}, 1);
        chk("ovf_head", tr_data_o, 32'h100);
        tr_ready_i = 1;
        cycle();
        cycle();
        cycle();
        v = '{32'h200, 32'h0, 0, 5'd0, 32'h0, 0, 7'h0, 32'h0, 16'h0, 32'h0};
        apply_vec(v);
        cycle();
        clear_in();
        chk("full_pop_drop", {24'd0, drop_cnt_o}, 2);
        chk("full_pop_stall", {31'd0, stall_o}, 1);
        wait_beats(16, 30, 0, used);
        chk("no_bubble", used, 12);
        for (int r = 0; r < 4; r++)
            check_rec("ovf_rec", 4*r, 32'h100 + 32'(4*r), 32'h8C000000 | 32'(r),
                      {16'(r), 16'h0020 | 16'(r+1)}, 32'h1000 + 32'(r));
        cycle();
        chk("ovf_drained", {31'd0, tr_valid_o}, 0);
        chk("ovf_unstall", {31'd0, stall_o}, 0);

        // Two records under alternating ready; seq continues at 6 (5 was the drop).
        rx_data.delete();
        rx_last.delete();
        tr_ready_i = 0;
        apply_vec(vecs[2]);
        cycle();
        apply_vec(vecs[3]);
        cycle();
        clear_in();
        prev_hold = 0;
        stab_en = 1;
        wait_beats(8, 60, 1, used);
        stab_en = 0;
        tr_ready_i = 1;
        check_rec("bp_rec0", 0, vecs[2].pc, vecs[2].instr, {16'd6, vecs[2].exp_lo}, vecs[2].exp_b3);
        check_rec("bp_rec1", 4, vecs[3].pc, vecs[3].instr, {16'd7, vecs[3].exp_lo}, vecs[3].exp_b3);

        // Reset while the FSM is offering beat2.
        rx_data.delete();
        rx_last.delete();
        apply_vec(vecs[0]);
        cycle();
        clear_in();
        cycle();
        cycle();
        cycle();
        chk("mid_b2", tr_data_o, {16'd8, vecs[0].exp_lo});
        rst_i = 1;
        #1;
        chk("async_valid", {31'd0, tr_valid_o}, 0);
        chk("async_last", {31'd0, tr_last_o}, 0);
        chk("async_data", tr_data_o, 0);
        cycle();
        cycle();
        rst_i = 0;
        cycle();
        cycle();
        cycle();
        chk("post_rst_quiet", {31'd0, tr_valid_o}, 0);
        chk("post_rst_beats", rx_data.size(), 2);
        rx_data.delete();
        rx_last.delete();
        apply_vec(vecs[1]);
        cycle();
        clear_in();
        wait_beats(4, 20, 0, used);
        check_rec("post_rst", 0, vecs[1].pc, vecs[1].instr, {16'd0, vecs[1].exp_lo}, vecs[1].exp_b3);

        // 65536 back-to-back retires wrap seq; most are dropped, counter saturates.
        do_reset();
        v = '{32'h300, 32'h0, 0, 5'd0, 32'h0, 0, 7'h0, 32'h0, 16'h0, 32'h0};
        apply_vec(v);
        for (int n = 0; n < 65536; n++) cycle();
        clear_in();
        used = 0;
        while (tr_valid_o && used < 40) begin
            cycle();
            used++;
        end
        chk("wrap_drained", {31'd0, tr_valid_o}, 0);
        chk("wrap_drop_sat", {24'd0, drop_cnt_o}, 32'hFF);
        chk("wrap_ovf", {31'd0, overflow_o}, 1);
        rx_data.delete();
        rx_last.delete();
        apply_vec(vecs[2]);
        cycle();
        clear_in();
        wait_beats(4, 20, 0, used);
        check_rec("wrap", 0, vecs[2].pc, vecs[2].instr, {16'h0000, vecs[2].exp_lo}, vecs[2].exp_b3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
